// File: rtl/mdio_pkg.sv
// Shared encodings and frame geometry for the Clause-22 MDIO controller.
// MDIO_PREAMBLE_EN (optional) enables the 32-bit preamble ahead of each frame.
package mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_DONE
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int FRAME_BITS     = 32;
  localparam int PREAMBLE_BITS  = 32;
  localparam int TA_BIT         = 14;
  localparam int DATA_FIRST_BIT = 16;

  function automatic logic is_read_op(input logic [31:0] f);
    return f[29:28] == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: low for MDC_DIV cycles then high for MDC_DIV cycles per bit,
// with 1-CLK strobes at the MDC rising edge and on the last cycle of a bit.
module mdio_clk_gen #(
  parameter int MDC_DIV = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic mdc,
  output logic mdc_rise,
  output logic bit_end
);

  localparam int CW = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mdc      = en && (cnt >= HALF);
  assign mdc_rise = en && (cnt == HALF);
  assign bit_end  = en && (cnt == LAST);

endmodule

// File: rtl/mdio_controller.sv
// Clause-22 MDIO initiator: serializes a 32-bit frame and captures read data.
// Define MDIO_PREAMBLE_EN to send 32 preamble ones before every frame.
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OE,
  output logic        MDIO_OUT,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  mdio_state_e state_q, state_d;
  logic [4:0]  bit_cnt;
  logic [31:0] frame_q;
  logic [15:0] rd_shift;
  logic        is_rd;
  logic        frame_bit;
  logic        last_bit;
  logic        gen_en, gen_clr;
  logic        mdc, mdc_rise, bit_end;
  logic        oe, out, rdy;
`ifdef MDIO_PREAMBLE_EN
  logic [4:0]  pre_cnt;
`endif

  assign is_rd     = is_read_op(frame_q);
  assign frame_bit = frame_q[5'(FRAME_BITS-1) - bit_cnt];
  assign last_bit  = bit_cnt == 5'(FRAME_BITS-1);
  assign gen_en    = (state_q == ST_FRAME) || (state_q == ST_PREAMBLE);
  assign gen_clr   = state_q == ST_IDLE;

  mdio_clk_gen #(
    .MDC_DIV(MDC_DIV)
  ) u_clk_gen (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (gen_en),
    .clr      (gen_clr),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d = state_q;
    oe      = 1'b0;
    out     = 1'b0;
    rdy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MDIO_START) begin
`ifdef MDIO_PREAMBLE_EN
          state_d = ST_PREAMBLE;
`else
          state_d = ST_FRAME;
`endif
        end
      end
`ifdef MDIO_PREAMBLE_EN
      ST_PREAMBLE: begin
        oe  = 1'b1;
        out = 1'b1;
        if (bit_end && pre_cnt == 5'(PREAMBLE_BITS-1))
          state_d = ST_FRAME;
      end
`endif
      ST_FRAME: begin
        // reads hand the line to the PHY from the turnaround onward
        oe  = !(is_rd && bit_cnt >= 5'(TA_BIT));
        out = oe && frame_bit;
        if (bit_end && last_bit)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        rdy     = is_rd;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      bit_cnt  <= '0;
      frame_q  <= '0;
      rd_shift <= '0;
      RD_DATA  <= '0;
`ifdef MDIO_PREAMBLE_EN
      pre_cnt  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && MDIO_START) begin
        frame_q <= T_DATA;
        bit_cnt <= '0;
`ifdef MDIO_PREAMBLE_EN
        pre_cnt <= '0;
`endif
      end
`ifdef MDIO_PREAMBLE_EN
      if (state_q == ST_PREAMBLE && bit_end)
        pre_cnt <= pre_cnt + 1'b1;
`endif
      if (state_q == ST_FRAME && bit_end)
        bit_cnt <= bit_cnt + 1'b1;
      if (state_q == ST_FRAME && mdc_rise && is_rd &&
          bit_cnt >= 5'(DATA_FIRST_BIT))
        rd_shift <= {rd_shift[14:0], MDIO_IN};
      if (state_q == ST_DONE && is_rd)
        RD_DATA <= rd_shift;
    end
  end

  assign MDC      = mdc;
  assign MDIO_OE  = oe;
  assign MDIO_OUT = out;
  assign DATA_RDY = rdy;
  assign BUSY     = state_q != ST_IDLE;

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: PHY model on MDIO_IN, frame-level reference
// of the expected line activity, random and directed frames.
module tb_mdio_controller;

  localparam int D = 2;
`ifdef MDIO_PREAMBLE_EN
  localparam int P = 32;
`else
  localparam int P = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC, MDIO_OE, MDIO_OUT, DATA_RDY, BUSY;
  logic [15:0] RD_DATA;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] rd_model = '0;

  mdio_controller #(.MDC_DIV(D)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OE    (MDIO_OE),
    .MDIO_OUT   (MDIO_OUT),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_frame(input logic [31:0] td, input logic [15:0] rv,
                          input bit b2b, input int inj_bit,
                          input int rst_bit);
    bit rd;
    int tot, errs, busy_n, rdy_n, b, ph, i;
    logic [31:0] exp_out, exp_oe, cap_out, cap_oe;
    logic eo, ev;
    rd = td[29:28] == 2'b10;
    tot = (P + 32) * 2 * D;
    errs = 0; busy_n = 0; rdy_n = 0;
    cap_out = '0; cap_oe = '0;
    for (int k = 0; k < 32; k++) begin
      exp_oe[31-k]  = !(rd && k >= 14);
      exp_out[31-k] = exp_oe[31-k] & td[31-k];
    end
    if (!b2b) repeat ($urandom_range(1, 3)) @(negedge CLK);
    T_DATA = td;
    MDIO_START = 1'b1;
    @(negedge CLK);
    MDIO_START = 1'b0;
    T_DATA = $urandom;
    for (int c = 0; c < tot; c++) begin
      b  = c / (2 * D);
      ph = c % (2 * D);
      if (rst_bit >= 0 && b == P + rst_bit && ph == 1) begin
        RESET = 1'b0;
        #1;
        check("rst_outs", {MDC, MDIO_OE, MDIO_OUT, DATA_RDY, BUSY}, 0);
        check("rst_rd_data", RD_DATA, 0);
        rd_model = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        rdy_n = 0; busy_n = 0;
        repeat (4) begin
          @(negedge CLK);
          rdy_n += DATA_RDY;
          busy_n += BUSY;
        end
        check("post_rst_quiet", {busy_n[15:0], rdy_n[15:0]}, 0);
        return;
      end
      MDIO_START = (inj_bit >= 0 && b == P + inj_bit && ph == 1);
      if (MDIO_START) T_DATA = $urandom;
      if (ph == 0)
        MDIO_IN = (rd && b - P >= 16) ? rv[15-(b-P-16)] : 1'($urandom);
      if (b < P) begin
        eo = 1'b1; ev = 1'b1;
      end else begin
        i  = b - P;
        eo = exp_oe[31-i];
        ev = exp_out[31-i];
        if (ph == D) begin
          cap_out[31-i] = MDIO_OUT;
          cap_oe[31-i]  = MDIO_OE;
        end
      end
      if (BUSY !== 1'b1 || MDC !== (ph >= D) || MDIO_OE !== eo ||
          MDIO_OUT !== ev)
        errs++;
      rdy_n  += DATA_RDY;
      busy_n += BUSY;
      @(negedge CLK);
    end
    MDIO_START = 1'b0;
    busy_n += BUSY;
    rdy_n  += DATA_RDY;
    if (MDC !== 1'b0 || MDIO_OE !== 1'b0) errs++;
    check("done_rdy", DATA_RDY, rd);
    @(negedge CLK);
    rdy_n += DATA_RDY;
    check("idle_busy", BUSY, 0);
    if (rd) rd_model = rv;
    check("frame_bits", cap_out, exp_out);
    check("frame_oe", cap_oe, exp_oe);
    check("busy_len", busy_n, tot + 1);
    check("rdy_pulses", rdy_n, rd);
    check("cycle_errs", errs, 0);
    check("rd_data", RD_DATA, rd_model);
  endtask

  initial begin
    logic [31:0] td;
    RESET = 1'b0;
    MDIO_START = 1'b0;
    T_DATA = '0;
    MDIO_IN = 1'b0;
    #3;
    check("reset_outs", {MDC, MDIO_OE, MDIO_OUT, DATA_RDY, BUSY}, 0);
    check("reset_rd_data", RD_DATA, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    do_frame(32'h508A_ABCD, 16'h0, 0, -1, -1);
    do_frame(32'h608C_0000, 16'h1234, 0, -1, -1);
    do_frame(32'h508A_ABCD, 16'h0, 0, 10, -1);
    do_frame(32'h608C_0000, 16'hBEEF, 0, -1, 20);
    do_frame(32'h608C_0000, 16'hC3A5, 0, -1, -1);
    do_frame(32'h508A_ABCD, 16'h0, 0, -1, -1);
    do_frame(32'h608C_0000, 16'h5A0F, 1, -1, -1);
    for (int n = 0; n < 8; n++) begin
      td = $urandom;
      td[31:30] = 2'b01;
      if (n % 2 == 0) td[29:28] = 2'b10;
      do_frame(td, 16'($urandom), 1'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
